// File: rtl/baseline_sched.sv
// Sequencing controller for the 1 s -> 5 s -> 30 s -> 4 min baseline averaging cascade.
// Issues stage load strobes, tracks 30 s history fill, and keeps detection-period data out of it.
module baseline_sched #(
    parameter int SAMPLES_PER_SEC = 256,
    parameter int N0              = 5,
    parameter int N1              = 6,
    parameter int N2              = 8,
    parameter int SW              = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sample_valid,
    input  logic       freeze,
    output logic       stage0_load,
    output logic       stage1_load,
    output logic       stage2_load,
    output logic [3:0] fill2,
    output logic       baseline_valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        RUN    = 2'b01,
        FREEZE = 2'b10,
        RESYNC = 2'b11
    } state_t;

    localparam logic [SW-1:0] CNT_LAST  = SW'(SAMPLES_PER_SEC - 1);
    localparam logic [2:0]    G0_LAST   = 3'(N0 - 1);
    localparam logic [2:0]    G1_LAST   = 3'(N1 - 1);
    localparam logic [3:0]    FILL_FULL = 4'(N2);

    state_t        st_q, st_d;
    logic [SW-1:0] cnt_s, cnt_s_d;
    logic [2:0]    g0, g0_d;
    logic [2:0]    g1, g1_d;
    logic          p0, p0_d;
    logic          p1, p1_d;
    logic          p2, p2_d;
    logic [3:0]    fill_q, fill_d;
    logic          bv_q, bv_d;
    logic          active;
    logic          s2_open;

    always_comb begin
        active  = ~en;
        // freeze is checked combinationally so a coinciding pending 30 s load is dropped
        s2_open = ((st_q == FILL) || (st_q == RUN)) && !freeze;

        stage0_load = active && p0;
        stage1_load = active && p1;
        stage2_load = active && p2 && s2_open;

        st_d    = st_q;
        cnt_s_d = cnt_s;
        g0_d    = g0;
        g1_d    = g1;
        p0_d    = p0;
        p1_d    = p1;
        p2_d    = p2;
        fill_d  = fill_q;
        bv_d    = bv_q;

        if (active) begin
            // every enabled cycle consumes (or drops) whatever was pending
            p0_d = 1'b0;
            p1_d = 1'b0;
            p2_d = 1'b0;

            if (sample_valid) begin
                if (cnt_s == CNT_LAST) begin
                    cnt_s_d = '0;
                    p0_d    = 1'b1;
                end else begin
                    cnt_s_d = cnt_s + 1'b1;
                end
            end

            if (p0) begin
                if (g0 == G0_LAST) begin
                    g0_d = '0;
                    p1_d = 1'b1;
                end else begin
                    g0_d = g0 + 3'd1;
                end
            end

            if (p1) begin
                if (g1 == G1_LAST) begin
                    g1_d = '0;
                    p2_d = 1'b1;
                end else begin
                    g1_d = g1 + 3'd1;
                end
            end

            if (stage2_load) begin
                if (fill_q != FILL_FULL) fill_d = fill_q + 4'd1;
                if (fill_q == FILL_FULL - 4'd1) bv_d = 1'b1;
            end

            case (st_q)
                FILL: begin
                    if (freeze) st_d = FREEZE;
                    else if (fill_d == FILL_FULL) st_d = RUN;
                end
                RUN: begin
                    if (freeze) st_d = FREEZE;
                end
                FREEZE: begin
                    // restart the 30 s window so it only spans post-freeze data
                    if (!freeze) begin
                        st_d = RESYNC;
                        g1_d = '0;
                    end
                end
                RESYNC: begin
                    if (freeze) st_d = FREEZE;
                    else if (p1 && (g1 == G1_LAST)) st_d = (fill_q == FILL_FULL) ? RUN : FILL;
                end
                default: st_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= FILL;
            cnt_s  <= '0;
            g0     <= '0;
            g1     <= '0;
            p0     <= 1'b0;
            p1     <= 1'b0;
            p2     <= 1'b0;
            fill_q <= '0;
            bv_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_s  <= cnt_s_d;
            g0     <= g0_d;
            g1     <= g1_d;
            p0     <= p0_d;
            p1     <= p1_d;
            p2     <= p2_d;
            fill_q <= fill_d;
            bv_q   <= bv_d;
        end
    end

    assign fill2          = fill_q;
    assign baseline_valid = bv_q;
    assign state          = st_q;

endmodule

// File: tb/tb_baseline_sched.sv
// Bench for baseline_sched: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a totals-based behavioural model of the cascade.
module tb_baseline_sched;
    localparam int SPS = 4;
    localparam int N0  = 5;
    localparam int N1  = 6;
    localparam int N2  = 8;
    localparam int M_FILL = 0, M_RUN = 1, M_FRZ = 2, M_RSY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sample_valid = 1'b0;
    logic       freeze = 1'b0;
    logic       stage0_load, stage1_load, stage2_load, baseline_valid;
    logic [3:0] fill2;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    // model: running totals of samples and strobes; a strobe is due when a total crosses a multiple
    int m_smp, m_n0, m_n1, m_base, m_fill, m_mode;
    bit m_p2;
    bit m_valid = 1'b0;

    baseline_sched #(
        .SAMPLES_PER_SEC(SPS), .N0(N0), .N1(N1), .N2(N2), .SW(3)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid), .freeze(freeze),
        .stage0_load(stage0_load), .stage1_load(stage1_load), .stage2_load(stage2_load),
        .fill2(fill2), .baseline_valid(baseline_valid), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit e0();
        return !en && ((m_smp / SPS) > m_n0);
    endfunction

    function automatic bit e1();
        return !en && ((m_n0 / N0) > m_n1);
    endfunction

    function automatic bit e2();
        return !en && m_p2 && (m_mode == M_FILL || m_mode == M_RUN) && !freeze;
    endfunction

    // compare on the falling edge, then advance the model to what the next rising edge produces
    initial forever begin
        bit i0, i1, i2, wrap;
        @(negedge clk);
        if (m_valid) begin
            chk("stage0_load", stage0_load, e0());
            chk("stage1_load", stage1_load, e1());
            chk("stage2_load", stage2_load, e2());
            chk("fill2", fill2, m_fill);
            chk("baseline_valid", baseline_valid, (m_fill == N2));
            chk("state", state, m_mode);
        end
        if (rst) begin
            m_smp = 0; m_n0 = 0; m_n1 = 0; m_base = 0; m_fill = 0; m_mode = M_FILL; m_p2 = 0;
            m_valid = 1'b1;
        end else if (!en && m_valid) begin
            i0 = e0(); i1 = e1(); i2 = e2(); wrap = 0;
            if (i2 && m_fill < N2) m_fill++;
            if (i0) m_n0++;
            if (i1) begin
                m_n1++;
                wrap = (((m_n1 - m_base) % N1) == 0);
            end
            if (sample_valid) m_smp++;
            m_p2 = wrap;
            case (m_mode)
                M_FILL:  if (freeze) m_mode = M_FRZ; else if (m_fill == N2) m_mode = M_RUN;
                M_RUN:   if (freeze) m_mode = M_FRZ;
                M_FRZ:   if (!freeze) begin m_mode = M_RSY; m_base = m_n1; end
                default: if (freeze) m_mode = M_FRZ;
                         else if (i1 && (m_n1 - m_base) == N1) m_mode = (m_fill == N2) ? M_RUN : M_FILL;
            endcase
        end
    end

    task automatic drive(input logic r, input logic e, input logic sv, input logic fz);
        @(posedge clk); #1;
        rst = r; en = e; sample_valid = sv; freeze = fz;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  f0, f0b, f1, f2, k2, t8, fbv, s1cnt, s2cnt, nsamp;
        bit  found, done, got;
        logic fz;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s0", stage0_load, 0);
        chk("rst_s1", stage1_load, 0);
        chk("rst_s2", stage2_load, 0);
        chk("rst_fill", fill2, 0);
        chk("rst_bv", baseline_valid, 0);
        chk("rst_state", state, 0);

        // counting chain and fill-up, sample every cycle from reset release (cycle 1)
        f0 = 0; f0b = 0; f1 = 0; f2 = 0; k2 = 0; t8 = 0; fbv = 0;
        for (int c = 1; c <= 970; c++) begin
            drive(0, 0, 1, 0);
            @(negedge clk);
            if (stage0_load) begin
                if (f0 == 0) f0 = c;
                else if (f0b == 0) f0b = c;
            end
            if (stage1_load && f1 == 0) f1 = c;
            if (stage2_load) begin
                k2++;
                if (f2 == 0) f2 = c;
                if (k2 == N2) t8 = c;
            end
            if (baseline_valid && fbv == 0) fbv = c;
        end
        chk("first_s0_cycle", f0, 5);
        chk("second_s0_cycle", f0b, 9);
        chk("first_s1_cycle", f1, 22);
        chk("first_s2_cycle", f2, 123);
        chk("eighth_s2_cycle", t8, 963);
        chk("bv_rise_cycle", fbv, 964);
        chk("s2_count", k2, 8);
        chk("fill_sat", fill2, 8);
        chk("run_state", state, 1);

        // stall on the cycle stage1_load is due
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            rst = 0; sample_valid = 1; freeze = 0;
            if ((m_n0 / N0) > m_n1) begin en = 1; found = 1; end
            else en = 0;
        end
        chk("stall_found", found, 1);
        @(negedge clk);
        chk("stall_s0", stage0_load, 0);
        chk("stall_s1", stage1_load, 0);
        chk("stall_s2", stage2_load, 0);
        repeat (2) begin
            drive(0, 1, 1, 0);
            @(negedge clk);
            chk("stall_s0", stage0_load, 0);
            chk("stall_s1", stage1_load, 0);
            chk("stall_s2", stage2_load, 0);
        end
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("stall_release_s1", stage1_load, 1);

        // freeze for 70 s of samples, then release and resync
        s2cnt = 0;
        repeat (70 * SPS) begin
            drive(0, 0, 1, 1);
            @(negedge clk);
            if (stage2_load) s2cnt++;
        end
        chk("freeze_no_s2", s2cnt, 0);
        chk("freeze_state", state, 2);
        chk("freeze_fill", fill2, 8);
        chk("freeze_bv", baseline_valid, 1);
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("release_state", state, 2);
        s1cnt = 0; s2cnt = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            drive(0, 0, 1, 0);
            @(negedge clk);
            if (i == 0) chk("resync_state", state, 3);
            if (s1cnt == N1) begin
                chk("resync_exit_state", state, 1);
                chk("resync_first_s2", stage2_load, 1);
                done = 1;
            end else begin
                if (stage2_load) s2cnt++;
                if (stage1_load) s1cnt++;
            end
        end
        chk("resync_done", done, 1);
        chk("resync_no_s2", s2cnt, 0);

        // freeze raised in the same cycle a 30 s load is pending (full history)
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            rst = 0; en = 0; sample_valid = 1;
            if (m_p2 && m_mode == M_RUN) begin freeze = 1; found = 1; end
            else freeze = 0;
        end
        chk("coll8_found", found, 1);
        @(negedge clk);
        chk("coll8_s2", stage2_load, 0);
        drive(0, 0, 1, 1);
        @(negedge clk);
        chk("coll8_fill", fill2, 8);
        chk("coll8_state", state, 2);
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            drive(0, 0, 1, 0);
            if (m_mode == M_RUN) done = 1;
        end
        chk("coll8_back_run", done, 1);

        // restart, fill to 4, then collide while still filling
        drive(1, 0, 0, 0);
        done = 0;
        for (int i = 0; i < 700 && !done; i++) begin
            drive(0, 0, 1, 0);
            if (m_fill == 4) done = 1;
        end
        chk("fill4_reached", done, 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            rst = 0; en = 0; sample_valid = 1;
            if (m_p2 && m_mode == M_FILL) begin freeze = 1; found = 1; end
            else freeze = 0;
        end
        chk("coll4_found", found, 1);
        @(negedge clk);
        chk("coll4_s2", stage2_load, 0);
        drive(0, 0, 1, 1);
        @(negedge clk);
        chk("coll4_fill", fill2, 4);
        chk("coll4_state", state, 2);
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            drive(0, 0, 1, 0);
            if (m_mode == M_FILL) done = 1;
        end
        chk("resync_to_fill_seen", done, 1);
        @(negedge clk);
        chk("resync_to_fill_state", state, 0);

        // reach fill2=5, freeze, then reset mid-run
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            drive(0, 0, 1, 0);
            if (m_fill == 5) done = 1;
        end
        chk("fill5_reached", done, 1);
        repeat (3) drive(0, 0, 1, 1);
        @(negedge clk);
        chk("pre_rst_state", state, 2);
        chk("pre_rst_fill", fill2, 5);
        drive(1, 0, 1, 1);
        drive(0, 0, 1'($urandom_range(0, 1)), 0);
        @(negedge clk);
        chk("post_rst_s0", stage0_load, 0);
        chk("post_rst_s1", stage1_load, 0);
        chk("post_rst_s2", stage2_load, 0);
        chk("post_rst_fill", fill2, 0);
        chk("post_rst_bv", baseline_valid, 0);
        chk("post_rst_state", state, 0);
        nsamp = 0; got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (i > 0) begin
                drive(0, 0, 1'($urandom_range(0, 1)), 0);
                @(negedge clk);
            end
            if (stage0_load) begin
                chk("post_rst_s0_samples", nsamp, SPS);
                got = 1;
            end
            if (sample_valid) nsamp++;
        end
        chk("post_rst_s0_seen", got, 1);

        // randomized traffic: sparse samples, stalls, long freeze episodes, rare resets
        fz = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 149) == 0) fz = !fz;
            drive(($urandom_range(0, 1999) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), fz);
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
